// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - video/CPU arbiter for the shared single-port 16K screen RAM
//
// vram_wr_fifo: posted CPU write queue, entries {bank, addr, data}.
//   push/push_data enqueue, pop drops the head, head/count describe contents.
//
// vram_arbiter: one RAM slot per CLK edge, priority VID > RD > WR > IDLE.
//   CLK, nRESET                          clock, synchronous active-low reset
//   vid_req/vid_addr/vid_bank            video fetch request
//   vid_dout/vid_valid                   fetched byte, one-cycle pulse
//   cpu_wr/cpu_rd/cpu_addr/cpu_bank/cpu_din  CPU access strobes and operands
//   cpu_dout/cpu_rdy                     CPU read data, one-cycle pulse
//   cpu_busy                             stall request to CPU wait logic
//   wr_ovf                               sticky: a posted write was dropped
//   ram_addr/ram_din/ram_we/ram_dout     VRAM macro interface

module vram_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 22
) (
    input  logic                   CLK,
    input  logic                   nRESET,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // The caller never pushes when full nor pops when empty; pointers wrap
    // naturally because DEPTH is a power of two.
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

module vram_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = 13
) (
    input  logic          CLK,
    input  logic          nRESET,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    input  logic          vid_bank,
    output logic [7:0]    vid_dout,
    output logic          vid_valid,
    input  logic          cpu_wr,
    input  logic          cpu_rd,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_bank,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    cpu_dout,
    output logic          cpu_rdy,
    output logic          cpu_busy,
    output logic          wr_ovf,
    output logic [AW:0]   ram_addr,
    output logic [7:0]    ram_din,
    output logic          ram_we,
    input  logic [7:0]    ram_dout
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = AW + 9;

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_VID,
        SLOT_RD,
        SLOT_WR
    } slot_t;

    slot_t         slot;
    logic [EW-1:0] fifo_head;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_next;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;

    logic          rd_pend;
    logic          rd_pend_next;
    logic [AW:0]   rd_addr;
    logic          vid_fly;
    logic          rd_fly;
    logic          busy_next;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));

    // Full is judged before any same-cycle pop, so a write arriving while
    // full is dropped even if a slot frees an entry this very cycle.
    assign push = cpu_wr && !fifo_full;
    assign pop  = (slot == SLOT_WR);

    vram_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EW)
    ) u_wr_fifo (
        .CLK       (CLK),
        .nRESET    (nRESET),
        .push      (push),
        .push_data ({cpu_bank, cpu_addr, cpu_din}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    // A read only goes once the queue is empty, which keeps read-after-write
    // coherent: any write accepted on or before the read's edge drains first.
    always_comb begin
        slot = SLOT_IDLE;
        if (vid_req)
            slot = SLOT_VID;
        else if (rd_pend && fifo_empty)
            slot = SLOT_RD;
        else if (!fifo_empty)
            slot = SLOT_WR;
    end

    always_comb begin
        count_next = fifo_count;
        if (push && !pop)
            count_next = fifo_count + CW'(1);
        else if (!push && pop)
            count_next = fifo_count - CW'(1);
    end

    // A strobe while a read is already pending is ignored, including in the
    // cycle that pending read takes its slot.
    assign rd_pend_next = rd_pend ? (slot != SLOT_RD) : cpu_rd;

    // Busy is registered from next-state so it drops together with cpu_rdy.
    assign busy_next = (count_next == CW'(FIFO_DEPTH)) || rd_pend_next
                       || (slot == SLOT_RD);

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            ram_addr  <= '0;
            ram_din   <= '0;
            ram_we    <= 1'b0;
            rd_pend   <= 1'b0;
            rd_addr   <= '0;
            vid_fly   <= 1'b0;
            rd_fly    <= 1'b0;
            vid_valid <= 1'b0;
            vid_dout  <= '0;
            cpu_rdy   <= 1'b0;
            cpu_dout  <= '0;
            cpu_busy  <= 1'b0;
            wr_ovf    <= 1'b0;
        end else begin
            case (slot)
                SLOT_VID: begin
                    ram_addr <= {vid_bank, vid_addr};
                    ram_we   <= 1'b0;
                end
                SLOT_RD: begin
                    ram_addr <= rd_addr;
                    ram_we   <= 1'b0;
                end
                SLOT_WR: begin
                    ram_addr <= fifo_head[EW-1:8];
                    ram_din  <= fifo_head[7:0];
                    ram_we   <= 1'b1;
                end
                default: ram_we <= 1'b0;
            endcase

            rd_pend <= rd_pend_next;
            if (!rd_pend && cpu_rd)
                rd_addr <= {cpu_bank, cpu_addr};

            // RAM data arrives a cycle after the address is registered.
            vid_fly   <= (slot == SLOT_VID);
            rd_fly    <= (slot == SLOT_RD);
            vid_valid <= vid_fly;
            cpu_rdy   <= rd_fly;
            if (vid_fly) vid_dout <= ram_dout;
            if (rd_fly)  cpu_dout <= ram_dout;

            cpu_busy <= busy_next;
            if (cpu_wr && fifo_full)
                wr_ovf <= 1'b1;
        end
    end

endmodule
